vec_bitwise_sequencer: RTL and testbench

- Issue/sequencing front end for the coprocessor's 32-bit bitwise operation unit.
- Accepts one vector bitwise instruction (AND/OR/XOR) and walks its elements.
- Reads element pairs from the vector register file and drives operands and control into the combinational bitwise unit. Writes each result back.
- Sits between the instruction dispatch and the vector register file. Throughput is one element per clock.

---
 rtl/vec_bitwise_sequencer.sv | 150 +++++++++++++++
 tb/tb_vec_bitwise_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_bitwise_sequencer.sv
// Issue/sequencing front end for the 32-bit bitwise unit: walks one AND/OR/XOR vector
// instruction at one element per clock. Optional per-element write mask under VSEQ_MASK_EN.
module vec_bitwise_sequencer #(
    parameter int unsigned VLEN_MAX = 32,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned VREG_W   = 5,
    parameter int unsigned ELEM_W   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [VREG_W-1:0]       req_vs1,
    input  logic [VREG_W-1:0]       req_vs2,
    input  logic [VREG_W-1:0]       req_vd,
    input  logic [IDX_W:0]          req_vl,
`ifdef VSEQ_MASK_EN
    input  logic [VLEN_MAX-1:0]     req_mask,
`endif
    output logic                    rf_rd_en,
    output logic [VREG_W+IDX_W-1:0] rf_rd_addr_a,
    output logic [VREG_W+IDX_W-1:0] rf_rd_addr_b,
    input  logic [ELEM_W-1:0]       rf_rd_data_a,
    input  logic [ELEM_W-1:0]       rf_rd_data_b,
    output logic [ELEM_W-1:0]       bu_operand_a,
    output logic [ELEM_W-1:0]       bu_operand_b,
    output logic [1:0]              bu_control,
    input  logic [ELEM_W-1:0]       bu_result,
    output logic                    rf_wr_en,
    output logic [VREG_W+IDX_W-1:0] rf_wr_addr,
    output logic [ELEM_W-1:0]       rf_wr_data,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    localparam logic [IDX_W:0]   VlMax  = (IDX_W+1)'(VLEN_MAX);
    localparam logic [IDX_W:0]   VlOne  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IdxOne = IDX_W'(1);

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [VREG_W-1:0]   vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
    logic [IDX_W:0]      vl_q, vl_d;
    logic [IDX_W-1:0]    idx_q, idx_d, s1_idx_q, s1_idx_d;
    logic                s1_valid_q, s1_valid_d;
    logic [IDX_W:0]      vl_eff;
    logic                last_rd;
`ifdef VSEQ_MASK_EN
    logic [VLEN_MAX-1:0] mask_q, mask_d;
`endif

    assign vl_eff  = (req_vl > VlMax) ? VlMax : req_vl;
    assign last_rd = ({1'b0, idx_q} == (vl_q - VlOne));

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        vs1_d      = vs1_q;
        vs2_d      = vs2_q;
        vd_d       = vd_q;
        vl_d       = vl_q;
        idx_d      = idx_q;
        s1_valid_d = 1'b0;
        s1_idx_d   = idx_q;
`ifdef VSEQ_MASK_EN
        mask_d     = mask_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op;
                    vs1_d   = req_vs1;
                    vs2_d   = req_vs2;
                    vd_d    = req_vd;
                    vl_d    = vl_eff;
                    idx_d   = '0;
`ifdef VSEQ_MASK_EN
                    mask_d  = req_mask;
`endif
                    state_d = (vl_eff == '0) ? StDrain : StRun;
                end
            end
            StRun: begin
                s1_valid_d = 1'b1;
                // Hold idx on the last read so it never wraps when vl_eff == VLEN_MAX.
                if (last_rd) begin
                    state_d = StDrain;
                end else begin
                    idx_d = idx_q + IdxOne;
                end
            end
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= '0;
            vs1_q      <= '0;
            vs2_q      <= '0;
            vd_q       <= '0;
            vl_q       <= '0;
            idx_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
`ifdef VSEQ_MASK_EN
            mask_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            vs1_q      <= vs1_d;
            vs2_q      <= vs2_d;
            vd_q       <= vd_d;
            vl_q       <= vl_d;
            idx_q      <= idx_d;
            s1_valid_q <= s1_valid_d;
            s1_idx_q   <= s1_idx_d;
`ifdef VSEQ_MASK_EN
            mask_q     <= mask_d;
`endif
        end
    end

    // Address/data outputs are forced to zero whenever their strobe stage is inactive.
    always_comb begin
        req_ready    = (state_q == StIdle);
        busy         = (state_q != StIdle);
        done         = (state_q == StDrain);
        rf_rd_en     = (state_q == StRun);
        rf_rd_addr_a = rf_rd_en ? {vs1_q, idx_q} : '0;
        rf_rd_addr_b = rf_rd_en ? {vs2_q, idx_q} : '0;
        bu_operand_a = s1_valid_q ? rf_rd_data_a : '0;
        bu_operand_b = s1_valid_q ? rf_rd_data_b : '0;
        bu_control   = s1_valid_q ? op_q : 2'b00;
`ifdef VSEQ_MASK_EN
        rf_wr_en     = s1_valid_q & mask_q[s1_idx_q];
`else
        rf_wr_en     = s1_valid_q;
`endif
        rf_wr_addr   = s1_valid_q ? {vd_q, s1_idx_q} : '0;
        rf_wr_data   = s1_valid_q ? bu_result : '0;
    end

endmodule

// File: tb/tb_vec_bitwise_sequencer.sv
// Self-checking bench for vec_bitwise_sequencer: behavioural register file and bitwise unit,
// cycle-exact timing expectations derived from vl_eff. Mask scenario runs under VSEQ_MASK_EN.
module tb_vec_bitwise_sequencer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [4:0]  req_vs1, req_vs2, req_vd;
    logic [5:0]  req_vl;
    logic [31:0] req_mask;
    logic        rf_rd_en;
    logic [9:0]  rf_rd_addr_a, rf_rd_addr_b;
    logic [31:0] rf_rd_data_a, rf_rd_data_b;
    logic [31:0] bu_operand_a, bu_operand_b;
    logic [1:0]  bu_control;
    logic [31:0] bu_result;
    logic        rf_wr_en;
    logic [9:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        busy, done;

    int checks = 0;
    int failures = 0;

    logic [31:0] rf  [1024];
    logic [31:0] pre [1024];
    logic        load;

    vec_bitwise_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_vs1      (req_vs1),
        .req_vs2      (req_vs2),
        .req_vd       (req_vd),
        .req_vl       (req_vl),
`ifdef VSEQ_MASK_EN
        .req_mask     (req_mask),
`endif
        .rf_rd_en     (rf_rd_en),
        .rf_rd_addr_a (rf_rd_addr_a),
        .rf_rd_addr_b (rf_rd_addr_b),
        .rf_rd_data_a (rf_rd_data_a),
        .rf_rd_data_b (rf_rd_data_b),
        .bu_operand_a (bu_operand_a),
        .bu_operand_b (bu_operand_b),
        .bu_control   (bu_control),
        .bu_result    (bu_result),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: synchronous read data one cycle after the strobe, write on the edge.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 1024; i++) rf[i] <= pre[i];
        end else if (rf_wr_en) begin
            rf[rf_wr_addr] <= rf_wr_data;
        end
        if (rf_rd_en) begin
            rf_rd_data_a <= rf[rf_rd_addr_a];
            rf_rd_data_b <= rf[rf_rd_addr_b];
        end
    end

    always_comb begin
        case (bu_control)
            2'b00:   bu_result = bu_operand_a & bu_operand_b;
            2'b01:   bu_result = bu_operand_a | bu_operand_b;
            2'b10:   bu_result = bu_operand_a ^ bu_operand_b;
            default: bu_result = 32'h0;
        endcase
    end

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        if (op == 2'd0) return a & b;
        if (op == 2'd1) return a | b;
        if (op == 2'd2) return a ^ b;
        return 32'h0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_rf();
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [4:0] vs1, input logic [4:0] vs2,
                             input logic [4:0] vd, input logic [5:0] vl, input logic [31:0] mask);
        req_valid = 1'b1;
        req_op    = op;
        req_vs1   = vs1;
        req_vs2   = vs2;
        req_vd    = vd;
        req_vl    = vl;
        req_mask  = mask;
    endtask

    // Runs one instruction starting in the current cycle (cycle 0), checks every cycle through
    // the done cycle, then the destination register contents. Returns in cycle vl_eff+2.
    task automatic run_instr(input logic [1:0] op, input logic [4:0] vs1, input logic [4:0] vs2,
                             input logic [4:0] vd, input logic [5:0] vl, input logic [31:0] mask,
                             input bit noisy);
        int          vle;
        logic [31:0] m;
        logic [31:0] res    [32];
        logic [31:0] exp_vd [32];
        logic [4:0]  exp_flags, got_flags;
        bit          exp_rd, exp_wr;
        vle = (vl > 6'd32) ? 32 : int'(vl);
`ifdef VSEQ_MASK_EN
        m = mask;
`else
        m = '1;
`endif
        for (int i = 0; i < 32; i++) begin
            res[i]    = ref_op(op, rf[{vs1, 5'(i)}], rf[{vs2, 5'(i)}]);
            exp_vd[i] = rf[{vd, 5'(i)}];
        end
        for (int i = 0; i < vle; i++) if (m[i]) exp_vd[i] = res[i];
        drive_req(op, vs1, vs2, vd, vl, mask);
        for (int c = 0; c <= vle + 1; c++) begin
            @(negedge clk);
            exp_rd = (c >= 1) && (c <= vle);
            exp_wr = 1'b0;
            if (c >= 2 && c <= vle + 1) exp_wr = m[c-2];
            exp_flags = {c == 0, c >= 1, c == vle + 1, exp_rd, exp_wr};
            got_flags = {req_ready, busy, done, rf_rd_en, rf_wr_en};
            checks++;
            if (got_flags !== exp_flags) begin
                failures++;
                $display("FAIL flags{ready,busy,done,rd,wr} cycle=%0d vl=%0d got=%b exp=%b",
                         c, vl, got_flags, exp_flags);
            end
            if (exp_rd) begin
                checks++;
                if ({rf_rd_addr_a, rf_rd_addr_b} !== {vs1, 5'(c - 1), vs2, 5'(c - 1)}) begin
                    failures++;
                    $display("FAIL rd_addr cycle=%0d got=%h/%h exp=%h/%h", c, rf_rd_addr_a,
                             rf_rd_addr_b, {vs1, 5'(c - 1)}, {vs2, 5'(c - 1)});
                end
            end
            if (c >= 2) begin
                checks++;
                if (bu_control !== op) begin
                    failures++;
                    $display("FAIL bu_control cycle=%0d got=%b exp=%b", c, bu_control, op);
                end
            end
            if (exp_wr) begin
                checks++;
                if (rf_wr_addr !== {vd, 5'(c - 2)} || rf_wr_data !== res[c-2]) begin
                    failures++;
                    $display("FAIL write cycle=%0d got=%h:%h exp=%h:%h", c, rf_wr_addr,
                             rf_wr_data, {vd, 5'(c - 2)}, res[c-2]);
                end
            end
            @(posedge clk);
            #1;
            if (noisy) begin
                req_op  = 2'($urandom);
                req_vs1 = 5'($urandom);
                req_vs2 = 5'($urandom);
                req_vd  = 5'($urandom);
                req_vl  = 6'($urandom_range(1, 40));
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (rf[{vd, 5'(i)}] !== exp_vd[i]) begin
                failures++;
                $display("FAIL vd_elem reg=%0d idx=%0d got=%h exp=%h", vd, i, rf[{vd, 5'(i)}],
                         exp_vd[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({req_ready, busy, done, rf_rd_en, rf_wr_en} !== 5'b10000) begin
                failures++;
                $display("FAIL reset_flags cycle=%0d got=%b exp=10000", c,
                         {req_ready, busy, done, rf_rd_en, rf_wr_en});
            end
            checks++;
            if ({rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr, rf_wr_data, bu_control,
                 bu_operand_a, bu_operand_b} !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d rda=%h rdb=%h wra=%h wrd=%h ctl=%b exp=0",
                         c, rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr, rf_wr_data, bu_control);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_and_directed();
        logic [31:0] a_v [4];
        logic [31:0] b_v [4];
        logic [31:0] e_v [4];
        a_v = '{32'hF0F0F0F0, 32'hFFFF0000, 32'h12345678, 32'h00000000};
        b_v = '{32'h0F0FFFFF, 32'h00FFFF00, 32'hFFFFFFFF, 32'hFFFFFFFF};
        e_v = '{32'h0000F0F0, 32'h00FF0000, 32'h12345678, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            pre[{5'd1, 5'(i)}] = a_v[i];
            pre[{5'd2, 5'(i)}] = b_v[i];
        end
        load_rf();
        run_instr(2'b00, 5'd1, 5'd2, 5'd3, 6'd4, '1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rf[{5'd3, 5'(i)}] !== e_v[i]) begin
                failures++;
                $display("FAIL and_directed idx=%0d got=%h exp=%h", i, rf[{5'd3, 5'(i)}], e_v[i]);
            end
        end
        idle(2);
    endtask

    task automatic test_mid_reset();
        logic [31:0] orig [8];
        logic [31:0] expv;
        for (int i = 0; i < 8; i++) orig[i] = rf[{5'd9, 5'(i)}];
        drive_req(2'b01, 5'd7, 5'd8, 5'd9, 6'd8, '1);
        idle(1);
        req_valid = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({req_ready, busy, done, rf_rd_en, rf_wr_en} !== 5'b10000) begin
                failures++;
                $display("FAIL abort_flags cycle=%0d got=%b exp=10000", c,
                         {req_ready, busy, done, rf_rd_en, rf_wr_en});
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 8; i++) begin
            expv = (i < 3) ? (rf[{5'd7, 5'(i)}] | rf[{5'd8, 5'(i)}]) : orig[i];
            checks++;
            if (rf[{5'd9, 5'(i)}] !== expv) begin
                failures++;
                $display("FAIL abort_vd idx=%0d got=%h exp=%h", i, rf[{5'd9, 5'(i)}], expv);
            end
        end
    endtask

    task automatic test_back_to_back(input int n);
        for (int k = 0; k < n; k++) begin
            run_instr(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                      6'($urandom_range(0, 40)), $urandom, 1'($urandom));
        end
        idle(2);
    endtask

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_vs1   = '0;
        req_vs2   = '0;
        req_vd    = '0;
        req_vl    = '0;
        req_mask  = '0;
        for (int i = 0; i < 1024; i++) pre[i] = $urandom;
        @(posedge clk);
        #1;
        load_rf();
        test_reset();
        test_and_directed();
        // XOR over-length with destination aliased onto source A
        run_instr(2'b10, 5'd4, 5'd5, 5'd4, 6'd40, '1, 1'b0);
        idle(1);
        run_instr(2'b01, 5'd10, 5'd11, 5'd12, 6'd0, '1, 1'b0);
        idle(1);
        run_instr(2'b11, 5'd13, 5'd14, 5'd15, 6'd6, '1, 1'b1);
        idle(1);
        run_instr(2'b01, 5'd16, 5'd17, 5'd17, 6'd32, '1, 1'b1);
        idle(1);
        test_mid_reset();
`ifdef VSEQ_MASK_EN
        run_instr(2'b00, 5'd1, 5'd2, 5'd20, 6'd4, 32'h5, 1'b0);
        idle(1);
`endif
        test_back_to_back(16);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
